move_rate_gen: RTL

- Multi-channel movement-rate generator for the colour-wheel game objects.
- A frame divider turns the system clock into a 60 Hz frame tick.
- Each of N_CH channels turns frame ticks into one-cycle "step" pulses, one per programmable number of frames (default 15).
- Per-channel period is loadable and can be sped up at runtime, so object speed rises as the game progresses.

---
 rtl/move_rate_gen_if.sv | 40 ++++
 rtl/move_rate_gen.sv | 119 +++++++++++
 2 files changed

// File: rtl/move_rate_gen_if.sv
// Control/status bundle for the movement-rate generator.
// Latency: none, plain wires between the game controller and the generator.
// Backpressure: none, every pulse is accepted on the edge it is presented.
//
// Signals:
//   enable       global run; low freezes the frame divider
//   ch_enable    per-channel run
//   ch_restart   per-channel pulse, restart that channel's frame count
//   speed_up     per-channel pulse, shorten that channel's period by one frame
//   period_load  per-channel pulse, load period_in into that channel's period
//   period_in    shared period value for period_load
//   frame_tick   one-cycle registered pulse per frame
//   step         one-cycle registered movement pulse per channel
//   ch_period    current periods, channel i at [i*PER_W +: PER_W]
interface move_rate_gen_if #(
    parameter int N_CH  = 4,
    parameter int PER_W = 5
);
    logic                    enable;
    logic [N_CH-1:0]         ch_enable;
    logic [N_CH-1:0]         ch_restart;
    logic [N_CH-1:0]         speed_up;
    logic [N_CH-1:0]         period_load;
    logic [PER_W-1:0]        period_in;
    logic                    frame_tick;
    logic [N_CH-1:0]         step;
    logic [N_CH*PER_W-1:0]   ch_period;

    // Controller side: drives the controls, observes the pulses and periods.
    modport master (
        output enable, ch_enable, ch_restart, speed_up, period_load, period_in,
        input  frame_tick, step, ch_period
    );

    // Generator side.
    modport slave (
        input  enable, ch_enable, ch_restart, speed_up, period_load, period_in,
        output frame_tick, step, ch_period
    );
endinterface

// File: rtl/move_rate_gen.sv
// Multi-channel movement-rate generator: frame divider plus per-channel step dividers.
// Latency: frame_tick registered on the reload edge; step one cycle after frame_tick.
// Backpressure: none, all control pulses take effect on the edge they are sampled.
//
// Ports:
//   clock   system clock, all state on its rising edge
//   resetb  synchronous active-high reset, priority over everything else
//   bus     move_rate_gen_if.slave: controls in, frame_tick/step/ch_period out
module move_rate_gen #(
    parameter int FRAME_DIV   = 833333,
    parameter int FDIV_W      = 20,
    parameter int N_CH        = 4,
    parameter int PER_W       = 5,
    parameter int INIT_PERIOD = 15,
    parameter int MIN_PERIOD  = 1
) (
    input  logic             clock,
    input  logic             resetb,
    move_rate_gen_if.slave   bus
);

    localparam logic [FDIV_W-1:0] FDIV_RELOAD = FDIV_W'(FRAME_DIV - 1);
    localparam logic [PER_W-1:0]  P_INIT      = PER_W'(INIT_PERIOD);
    localparam logic [PER_W-1:0]  P_MIN       = PER_W'(MIN_PERIOD);

    // ---------------------------------------------------------------
    // Frame divider: counts down, ticks on the edge that reloads.
    // ---------------------------------------------------------------
    logic [FDIV_W-1:0] r_fcnt;
    logic              r_frame_tick;

    always_ff @(posedge clock) begin
        if (resetb) begin
            r_fcnt       <= FDIV_RELOAD;
            r_frame_tick <= 1'b0;
        end else if (bus.enable) begin
            if (r_fcnt == '0) begin
                r_fcnt       <= FDIV_RELOAD;
                r_frame_tick <= 1'b1;
            end else begin
                r_fcnt       <= r_fcnt - 1'b1;
                r_frame_tick <= 1'b0;
            end
        end else begin
            r_frame_tick <= 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // Per-channel period and frame count.
    // The channels consume the registered frame_tick, which is what puts
    // step exactly one cycle behind frame_tick.
    // ---------------------------------------------------------------
    logic [PER_W-1:0] r_period [N_CH];
    logic [PER_W-1:0] r_cnt    [N_CH];
    logic [N_CH-1:0]  r_step;

    logic [PER_W-1:0] w_new_period [N_CH];
    logic [PER_W-1:0] w_next_cnt   [N_CH];
    logic [N_CH-1:0]  w_next_step;

    always_comb begin
        w_next_step = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_new_period[i] = r_period[i];
            w_next_cnt[i]   = r_cnt[i];

            // Load beats speed_up; both saturate at the minimum period.
            if (bus.period_load[i]) begin
                w_new_period[i] = (bus.period_in < P_MIN) ? P_MIN : bus.period_in;
            end else if (bus.speed_up[i]) begin
                w_new_period[i] = (r_period[i] > P_MIN) ? (r_period[i] - 1'b1) : P_MIN;
            end

            if (bus.ch_restart[i]) begin
                // Restart suppresses a coincident step.
                w_next_cnt[i] = w_new_period[i] - 1'b1;
            end else if (r_frame_tick && bus.ch_enable[i]) begin
                if (r_cnt[i] == '0) begin
                    // Reload from the period that was in force for this cycle.
                    w_next_cnt[i]  = r_period[i] - 1'b1;
                    w_next_step[i] = 1'b1;
                end else begin
                    w_next_cnt[i] = r_cnt[i] - 1'b1;
                end
            end else if (r_cnt[i] > (w_new_period[i] - 1'b1)) begin
                // A shortened period pulls an outstanding count into range.
                w_next_cnt[i] = w_new_period[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (resetb) begin
            for (int i = 0; i < N_CH; i++) begin
                r_period[i] <= P_INIT;
                r_cnt[i]    <= P_INIT - 1'b1;
            end
            r_step <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                r_period[i] <= w_new_period[i];
                r_cnt[i]    <= w_next_cnt[i];
            end
            r_step <= w_next_step;
        end
    end

    // ---------------------------------------------------------------
    // Outputs, all straight from registers.
    // ---------------------------------------------------------------
    assign bus.frame_tick = r_frame_tick;
    assign bus.step       = r_step;

    for (genvar g = 0; g < N_CH; g++) begin : g_per
        assign bus.ch_period[g*PER_W +: PER_W] = r_period[g];
    end

endmodule
